// File: rtl/calc_pkg.sv
// Shared op codes, FSM state encoding and sizing helper for the sequential calculator.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   // Any op_sel with bit 1 set selects multiply; bit 0 is a don't-care.
   localparam logic [1:0] OP_MUL = 2'b10;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic logic is_mul_op(input logic [1:0] op);
      return (op & OP_MUL) != 2'b00;
   endfunction

   // Bits needed for a counter that holds the values 0..w.
   function automatic int calc_cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_add_mul_nbit.sv
// Iterative unsigned shift-add multiplier; one multiplier bit per clock, WIDTH steps.
module shift_add_mul_nbit
   import calc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               fin,
   output logic [2*WIDTH-1:0] p
);

   localparam int CW = calc_cnt_width(WIDTH);

   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] p_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     upper;
   logic [2*WIDTH-1:0] p_step;

   // Low half of p_q holds the remaining multiplier bits; the upper half accumulates.
   always_comb begin
      upper  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
      p_step = {upper, p_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         p_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         a_q   <= a;
         p_q   <= {{WIDTH{1'b0}}, b};
         cnt_q <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
         p_q   <= p_step;
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign busy = (cnt_q != '0);
   // p is the product after this cycle's step, so it is final while fin is high.
   assign fin  = (cnt_q == CW'(1));
   assign p    = p_step;

endmodule

// File: rtl/seq_calc_nbit.sv
// Clocked WIDTH-bit add/sub/multiply with start/done handshake.
// Optional zero-result flag enabled by defining SEQ_CALC_ZERO_FLAG_EN.
module seq_calc_nbit
   import calc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic [1:0]         op_sel,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               overflow,
   output logic               carry_out
`ifdef SEQ_CALC_ZERO_FLAG_EN
   ,
   output logic               zero
`endif
);

   logic [1:0]         state, state_nxt;
   logic               accept, is_mul, mul_load, mul_fin;
   logic [WIDTH-1:0]   b_eff;
   logic               cin;
   logic [WIDTH:0]     addsub;
   logic               as_ovf;
   logic [2*WIDTH-1:0] mul_p;

   assign accept   = start && (state != CALC);
   assign is_mul   = is_mul_op(op_sel);
   assign mul_load = accept && is_mul;

   shift_add_mul_nbit #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (mul_load),
      .a     (x),
      .b     (y),
      .busy  (busy),
      .fin   (mul_fin),
      .p     (mul_p)
   );

   // Single adder; subtract is x + ~y + 1.
   always_comb begin
      b_eff = y;
      cin   = 1'b0;
      case (op_sel)
         OP_ADD:  ;
         OP_SUB: begin
            b_eff = ~y;
            cin   = 1'b1;
         end
         default: ;
      endcase
      addsub = {1'b0, x} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      as_ovf = (x[WIDTH-1] == b_eff[WIDTH-1]) && (addsub[WIDTH-1] != x[WIDTH-1]);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = is_mul ? CALC : DONE;
            else       state_nxt = IDLE;
         end
         CALC:    if (mul_fin) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         result    <= '0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept && !is_mul) begin
            result    <= {{WIDTH{addsub[WIDTH-1]}}, addsub[WIDTH-1:0]};
            overflow  <= as_ovf;
            carry_out <= addsub[WIDTH];
         end else if (state == CALC && mul_fin) begin
            result    <= mul_p;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
         end
      end
   end

`ifdef SEQ_CALC_ZERO_FLAG_EN
   // Add/sub judges only the WIDTH-bit sum, not the sign-extended result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else if (accept && !is_mul) begin
         zero <= (addsub[WIDTH-1:0] == '0);
      end else if (state == CALC && mul_fin) begin
         zero <= (mul_p == '0);
      end
   end
`endif

   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_calc_nbit.sv
// Directed bench for seq_calc_nbit at WIDTH=4 and WIDTH=8; zero flag checked when
// SEQ_CALC_ZERO_FLAG_EN is defined.
module tb_seq_calc_nbit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start4 = 1'b0, start8 = 1'b0;
   logic [3:0]  x4 = '0, y4 = '0;
   logic [7:0]  x8 = '0, y8 = '0;
   logic [1:0]  op4 = '0, op8 = '0;
   logic        busy4, done4, ovf4, co4;
   logic        busy8, done8, ovf8, co8;
   logic [7:0]  res4;
   logic [15:0] res8;
`ifdef SEQ_CALC_ZERO_FLAG_EN
   logic        zero4, zero8;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_calc_nbit #(.WIDTH(4)) u4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
      .x         (x4),
      .y         (y4),
      .op_sel    (op4),
      .busy      (busy4),
      .done      (done4),
      .result    (res4),
      .overflow  (ovf4),
      .carry_out (co4)
`ifdef SEQ_CALC_ZERO_FLAG_EN
      ,
      .zero      (zero4)
`endif
   );

   seq_calc_nbit #(.WIDTH(8)) u8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .x         (x8),
      .y         (y8),
      .op_sel    (op8),
      .busy      (busy8),
      .done      (done8),
      .result    (res8),
      .overflow  (ovf8),
      .carry_out (co8)
`ifdef SEQ_CALC_ZERO_FLAG_EN
      ,
      .zero      (zero8)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // done/busy/result/overflow/carry_out of the WIDTH=4 instance in one call.
   task automatic chk4(input string tag, input logic b, input logic d, input logic [7:0] r,
                       input logic o, input logic c);
      chk({tag, ".busy"}, 16'(busy4), 16'(b));
      chk({tag, ".done"}, 16'(done4), 16'(d));
      chk({tag, ".result"}, 16'(res4), 16'(r));
      chk({tag, ".overflow"}, 16'(ovf4), 16'(o));
      chk({tag, ".carry_out"}, 16'(co4), 16'(c));
   endtask

   initial begin
      // Reset state
      #2;
      chk4("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("reset8.result", res8, 16'h0000);
      tick();
      rst_n = 1'b1;
      tick();
      chk4("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // 7+1: signed overflow, sign-extended 0x8
      x4 = 4'd7; y4 = 4'd1; op4 = 2'b00; start4 = 1'b1;
      tick();
      start4 = 1'b0; x4 = 4'd0;
      chk4("add7p1", 1'b0, 1'b1, 8'hF8, 1'b1, 1'b0);
      tick();
      chk4("add7p1.after", 1'b0, 1'b0, 8'hF8, 1'b1, 1'b0);

      // 3-5 then back-to-back 5-3
      x4 = 4'd3; y4 = 4'd5; op4 = 2'b01; start4 = 1'b1;
      tick();
      chk4("sub3m5", 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      x4 = 4'd5; y4 = 4'd3;
      tick();
      start4 = 1'b0;
      chk4("sub5m3", 1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
      tick();
      chk4("sub5m3.hold", 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);

      // 15*15: busy cycles 1..4, result held until done in cycle 5
      x4 = 4'd15; y4 = 4'd15; op4 = 2'b11; start4 = 1'b1;
      tick();
      start4 = 1'b0; x4 = 4'd0; y4 = 4'd0; op4 = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         chk4($sformatf("mul15x15.c%0d", i), 1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
         if (i < 4) tick();
      end
      tick();
      chk4("mul15x15.c5", 1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
      tick();

      // 0*9
      x4 = 4'd0; y4 = 4'd9; op4 = 2'b10; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      repeat (4) tick();
      chk4("mul0x9", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`ifdef SEQ_CALC_ZERO_FLAG_EN
      chk("mul0x9.zero", 16'(zero4), 16'h1);
`endif
      tick();

      // 6*7 with an add start pulsed in cycle 2: ignored
      x4 = 4'd6; y4 = 4'd7; op4 = 2'b10; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("mul6x7.c1.done", 16'(done4), 16'h0);
      tick();
      x4 = 4'd1; y4 = 4'd1; op4 = 2'b00; start4 = 1'b1;
      chk("mul6x7.c2.busy", 16'(busy4), 16'h1);
      tick();
      start4 = 1'b0;
      chk("mul6x7.c3.done", 16'(done4), 16'h0);
      tick();
      chk("mul6x7.c4.done", 16'(done4), 16'h0);
      tick();
      chk4("mul6x7.c5", 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0);
`ifdef SEQ_CALC_ZERO_FLAG_EN
      chk("mul6x7.zero", 16'(zero4), 16'h0);
`endif
      tick();
      chk("mul6x7.c6.done", 16'(done4), 16'h0);

      // Reset during multiply in cycle 3: aborts, no done ever appears
      x4 = 4'd5; y4 = 4'd5; op4 = 2'b10; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      tick();
      chk("abort.c3.busy", 16'(busy4), 16'h1);
      rst_n = 1'b0;
      #1;
      chk4("abort.reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("abort.nodone%0d", i), 16'({busy4, done4}), 16'h0);
      end
      x4 = 4'd2; y4 = 4'd2; op4 = 2'b00; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk4("add2p2", 1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
`ifdef SEQ_CALC_ZERO_FLAG_EN
      chk("add2p2.zero", 16'(zero4), 16'h0);
`endif

      // WIDTH=8: 200*3 then add 100+100 started in the DONE cycle
      x8 = 8'd200; y8 = 8'd3; op8 = 2'b10; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (7) tick();
      chk("w8.mul.c8.busy", 16'(busy8), 16'h1);
      chk("w8.mul.c8.done", 16'(done8), 16'h0);
      tick();
      chk("w8.mul.c9.done", 16'(done8), 16'h1);
      chk("w8.mul.c9.result", res8, 16'h0258);
      chk("w8.mul.c9.carry", 16'(co8), 16'h0);
      x8 = 8'd100; y8 = 8'd100; op8 = 2'b00; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      chk("w8.add.done", 16'(done8), 16'h1);
      chk("w8.add.result", res8, 16'hFFC8);
      chk("w8.add.overflow", 16'(ovf8), 16'h1);
      chk("w8.add.carry", 16'(co8), 16'h0);
      tick();
      chk("w8.add.after.done", 16'(done8), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_calc_nbit.md
Name: seq_calc_nbit

Overview:
- Parametrised, clocked successor to the team's 4-bit combinational calculator.
- Performs add, subtract and unsigned multiply on WIDTH-bit operands behind a start/done handshake.
- Add/sub complete in one cycle. Multiply uses an iterative shift-add datapath, one operand bit per cycle, keeping area flat as WIDTH grows.
- Sits between operand registers/switch inputs and the display/result path.

Parameters:
- WIDTH, 4, operand width in bits (>=2); result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  operand A; captured on accepted start.
- y  input  WIDTH  operand B; captured on accepted start.
- op_sel  input  2  00 add, 01 subtract (x-y), 1x unsigned multiply (op_sel[0] ignored).
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  2*WIDTH  registered result, held until the next done.
- overflow  output  1  signed two's-complement overflow (add/sub only).
- carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow (x>=y unsigned).

Behaviour:
- Reset is asynchronous and active-low; one clock domain (clk).
- Reset (rst_n=0): state=IDLE; busy, done, overflow, carry_out = 0; result = 0; iteration counter = 0; operand/partial-product registers = 0.
- Reset asserted mid-multiply aborts the operation immediately. No done is produced.
- FSM states:
  - IDLE: waiting for start.
  - CALC: multiply iterating.
  - DONE: single cycle, done=1.
- Transitions:
  - IDLE or DONE, start=1, op add/sub -> DONE.
  - IDLE or DONE, start=1, op mul -> CALC.
  - DONE, start=0 -> IDLE.
  - CALC -> DONE after exactly WIDTH iterations.
- Accepted start is the edge at which start=1 and state!=CALC (call it edge 0). x, y and op_sel are latched there.
- Latency:
  - Add/sub: done=1 in cycle 1.
  - Multiply: busy=1 in cycles 1..WIDTH; done=1 in cycle WIDTH+1.
- start while busy=1 is ignored: no queueing, no effect on the running operation.
- start asserted during the DONE cycle is accepted (back-to-back operation allowed).
- Add/sub arithmetic:
  - Single WIDTH-bit adder; subtract = x + ~y + 1.
  - result[WIDTH-1:0] = sum; result[2*WIDTH-1:WIDTH] = sign extension of sum[WIDTH-1].
  - overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Multiply:
  - Unsigned x*y, exact in 2*WIDTH bits.
  - overflow=0 and carry_out=0 at done.
  - Iteration: if multiplier LSB is set, add multiplicand to the upper partial product; then shift right 1.
- result, overflow and carry_out change only on the edge entering DONE. They are stable otherwise, including while busy.
- Inputs x, y, op_sel may change freely after acceptance without affecting the operation in flight.

Optional Feature:
- Macro SEQ_CALC_ZERO_FLAG_EN.
- Defined: extra output port zero (1 bit, reset 0), updated with result on entering DONE. zero = 1 iff result == 0; for add/sub it evaluates the WIDTH-bit sum only.
- Undefined: no zero port and no zero-detect logic; all other behaviour identical.

Decomposition:
- Package calc_pkg holds:
  - op codes: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b1x match rule;
  - FSM state encoding: IDLE, CALC, DONE;
  - counter width function clog2(WIDTH+1).
- One sub-module: shift_add_mul_nbit (WIDTH param).
  - Ports: clk, rst_n, load, a, b, busy, fin, p.
  - Owns the iteration counter and partial product.
  - Parent owns the FSM, adder/subtractor, flags and output registers.

Test Plan:
- WIDTH=4, add 7+1 -> done in cycle 1; result=8'hF8, overflow=1, carry_out=0.
- WIDTH=4, sub 3-5 -> done in cycle 1; result=8'hFE, overflow=0, carry_out=0. Then sub 5-3 -> result=8'h02, carry_out=1.
- WIDTH=4, mul 15*15 -> busy high cycles 1-4, done in cycle 5; result=8'hE1, overflow=0, carry_out=0. Also mul 0*9 -> result=0 (zero=1 if enabled).
- WIDTH=4, mul 6*7 with start re-pulsed (op add 1+1) in cycle 2 -> second start ignored; single done in cycle 5 with result=8'h2A.
- WIDTH=4, mul in progress, rst_n low in cycle 3 -> all outputs 0 immediately, no done. After release, add 2+2 -> result=8'h04 in cycle 1.
- WIDTH=8, back-to-back: mul 200*3, start add 100+100 during the DONE cycle.
  - Mul result=16'h0258 at cycle 9.
  - Add result=16'hFFC8, overflow=1, carry_out=0 one cycle later.
